// File: rtl/alu_pkg.sv
// Shared encodings for the multi-cycle ALU: opcodes, funct3/funct7 values, FSM states.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  // Base integer ops
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // M-extension ops (Funct7 = F7_MULDIV)
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Sign/selection info captured when a divide is accepted.
  typedef struct packed {
    logic want_rem;
    logic q_neg;
    logic r_neg;
    logic div_zero;
  } div_ctl_t;

  // R-type base ops: Funct7 0x00 for all, 0x20 only for SUB and SRA.
  function automatic logic r_base_legal(input logic [6:0] f7, input logic [2:0] f3);
    return (f7 == F7_BASE) || ((f7 == F7_ALT) && ((f3 == F3_ADD) || (f3 == F3_SR)));
  endfunction

endpackage

// File: rtl/alu_div.sv
// Restoring radix-2 unsigned divider; first step happens on the start edge,
// so done rises WIDTH cycles after start.
module alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic [CW-1:0]    cnt;
  logic             busy;

  // One restoring step: shift the next dividend bit in, subtract if it fits.
  function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] r,
                                              input logic [WIDTH-1:0] q,
                                              input logic [WIDTH-1:0] d);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    sh   = {r, q[WIDTH-1]};
    diff = sh - {1'b0, d};
    if (diff[WIDTH]) step = {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    else             step = {diff[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
  endfunction

  // NOTE: sequential state is updated with non-blocking <= only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo  <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      {rem, quo} <= step('0, dividend, divisor);
      dvs        <= divisor;
      cnt        <= CW'(1);
      busy       <= 1'b1;
    end else if (busy) begin
      if (cnt == LAST) begin
        busy <= 1'b0;
      end else begin
        {rem, quo} <= step(rem, quo, dvs);
        cnt        <= cnt + CW'(1);
      end
    end
  end

  assign done      = busy && (cnt == LAST);
  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV-style integer ALU with valid/ready handshakes.
// Define ALU_MC_MDU_EN to build the M-extension (multiply + iterative divide).
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] RS1,
  input  logic [WIDTH-1:0] RS2,
  input  logic [11:0]      Imm_reg,
  input  logic [6:0]       opcode,
  input  logic [2:0]       Funct3,
  input  logic [6:0]       Funct7,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] RD,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic             is_imm;
  logic             is_alt;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] op_b;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0] base_res;
  logic [WIDTH-1:0] res;
  logic             res_ill;
  logic             is_div;
  logic             div_done;
  logic [WIDTH-1:0] div_res;

  assign is_imm  = (opcode == OPC_OP_IMM);
  assign imm_ext = {{(WIDTH-12){Imm_reg[11]}}, Imm_reg};
  assign op_b    = is_imm ? imm_ext : RS2;
  assign shamt   = op_b[SHW-1:0];
  assign is_alt  = is_imm ? Imm_reg[10] : (Funct7 == F7_ALT);
  assign sra_res = $signed(RS1) >>> shamt;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    base_res = '0;
    case (Funct3)
      F3_ADD:  base_res = (is_alt && !is_imm) ? (RS1 - op_b) : (RS1 + op_b);
      F3_SLL:  base_res = RS1 << shamt;
      F3_SLT:  base_res = {{(WIDTH-1){1'b0}}, ($signed(RS1) < $signed(op_b))};
      F3_SLTU: base_res = {{(WIDTH-1){1'b0}}, (RS1 < op_b)};
      F3_XOR:  base_res = RS1 ^ op_b;
      F3_SR:   base_res = is_alt ? sra_res : (RS1 >> shamt);
      F3_OR:   base_res = RS1 | op_b;
      F3_AND:  base_res = RS1 & op_b;
      default: base_res = '0;
    endcase
  end

`ifdef ALU_MC_MDU_EN
  logic [2*WIDTH-1:0] mul_a;
  logic [2*WIDTH-1:0] mul_b;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mul_res;
  logic               div_signed;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               div_start;
  logic               div_fin;
  logic [WIDTH-1:0]   quo_u;
  logic [WIDTH-1:0]   rem_u;
  div_ctl_t           ctl;

  // Sign-extend per operand signedness; the low 2*WIDTH bits of the product are exact.
  assign mul_a   = {{WIDTH{RS1[WIDTH-1] & (Funct3 != F3_MULHU)}}, RS1};
  assign mul_b   = {{WIDTH{RS2[WIDTH-1] & (Funct3 == F3_MULH)}}, RS2};
  assign prod    = mul_a * mul_b;
  assign mul_res = (Funct3 == F3_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

  // DIV/REM are even encodings; DIVU/REMU odd.
  assign div_signed = !Funct3[0];
  assign a_neg      = div_signed & RS1[WIDTH-1];
  assign b_neg      = div_signed & RS2[WIDTH-1];
  assign abs_a      = a_neg ? (-RS1) : RS1;
  assign abs_b      = b_neg ? (-RS2) : RS2;
  assign div_start  = (state == S_IDLE) && in_valid && is_div;

  alu_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (div_fin),
    .quotient  (quo_u),
    .remainder (rem_u)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl <= '0;
    end else if (div_start) begin
      ctl <= '{want_rem: Funct3[1], q_neg: a_neg ^ b_neg, r_neg: a_neg, div_zero: (RS2 == '0)};
    end
  end

  // min / -1 falls out of the magnitude path (|min| negated is min, remainder 0);
  // only the signed divide-by-zero quotient needs forcing to all-ones.
  always_comb begin
    div_res = '0;
    if (ctl.want_rem)      div_res = ctl.r_neg ? (-rem_u) : rem_u;
    else if (ctl.div_zero) div_res = '1;
    else                   div_res = ctl.q_neg ? (-quo_u) : quo_u;
  end

  assign div_done = div_fin;
`else
  assign div_done = 1'b0;
  assign div_res  = '0;
`endif

  always_comb begin
    res     = '0;
    res_ill = 1'b0;
    is_div  = 1'b0;
    if (opcode == OPC_OP_IMM) begin
      res = base_res;
    end else if (opcode == OPC_OP) begin
      if (r_base_legal(Funct7, Funct3)) begin
        res = base_res;
      end
`ifdef ALU_MC_MDU_EN
      else if (Funct7 == F7_MULDIV) begin
        if (Funct3[2]) is_div = 1'b1;
        else           res    = mul_res;
      end
`endif
      else begin
        res_ill = 1'b1;
      end
    end else begin
      res_ill = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      RD        <= '0;
      illegal   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_div) begin
              state <= S_DIV;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              RD        <= res;
              illegal   <= res_ill;
            end
          end
        end
        S_DIV: begin
          if (div_done) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            RD        <= div_res;
            illegal   <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc (WIDTH=32); M-extension vectors
// are compiled in when ALU_MC_MDU_EN is defined.
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] RS1;
  logic [W-1:0] RS2;
  logic [11:0]  Imm_reg;
  logic [6:0]   opcode;
  logic [2:0]   Funct3;
  logic [6:0]   Funct7;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] RD;
  logic         illegal;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .RS1       (RS1),
    .RS2       (RS2),
    .Imm_reg   (Imm_reg),
    .opcode    (opcode),
    .Funct3    (Funct3),
    .Funct7    (Funct7),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .RD        (RD),
    .illegal   (illegal)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Issue one op, scramble inputs after acceptance, measure latency, optionally
  // stall the result, then drain it.
  task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [11:0] imm, input logic [W-1:0] exp_rd, input logic exp_ill,
                        input int exp_lat, input int stall);
    int lat;
    @(negedge clk);
    check({tag, ":in_ready"}, in_ready, 1'b1);
    opcode = opc; Funct3 = f3; Funct7 = f7; RS1 = a; RS2 = b; Imm_reg = imm;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    RS1 = ~a; RS2 = ~b; Imm_reg = ~imm; Funct3 = ~f3; Funct7 = ~f7; opcode = 7'h7f;
    check({tag, ":busy"}, in_ready, 1'b0);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ":lat"}, lat, exp_lat);
    check({tag, ":rd"}, RD, exp_rd);
    check({tag, ":ill"}, illegal, exp_ill);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check({tag, ":hold"}, {in_ready, out_valid, illegal, RD}, {1'b0, 1'b1, exp_ill, exp_rd});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, ":drain"}, {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    RS1 = '0; RS2 = '0; Imm_reg = '0; opcode = '0; Funct3 = '0; Funct7 = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_rd", RD, 32'h0);
    check("rst_illegal", illegal, 1'b0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1'b1);

    // R-type base ops
    run_op("add",  OPC_OP, F3_ADD,  F7_BASE, 32'd3,        32'd4,        12'h0, 32'd7,        1'b0, 1, 0);
    run_op("sub",  OPC_OP, F3_ADD,  F7_ALT,  32'd5,        32'd7,        12'h0, 32'hFFFFFFFE, 1'b0, 1, 0);
    run_op("sll",  OPC_OP, F3_SLL,  F7_BASE, 32'd1,        32'h24,       12'h0, 32'h10,       1'b0, 1, 0);
    run_op("slt",  OPC_OP, F3_SLT,  F7_BASE, 32'hFFFFFFFF, 32'd1,        12'h0, 32'd1,        1'b0, 1, 0);
    run_op("sltu", OPC_OP, F3_SLTU, F7_BASE, 32'hFFFFFFFF, 32'd1,        12'h0, 32'd0,        1'b0, 1, 0);
    run_op("xor",  OPC_OP, F3_XOR,  F7_BASE, 32'hF0F0F0F0, 32'hFF00FF00, 12'h0, 32'h0FF00FF0, 1'b0, 1, 0);
    run_op("srl",  OPC_OP, F3_SR,   F7_BASE, 32'h80000000, 32'd4,        12'h0, 32'h08000000, 1'b0, 1, 0);
    run_op("sra",  OPC_OP, F3_SR,   F7_ALT,  32'h80000000, 32'd4,        12'h0, 32'hF8000000, 1'b0, 1, 0);
    run_op("or",   OPC_OP, F3_OR,   F7_BASE, 32'h0F0,      32'h00F,      12'h0, 32'h0FF,      1'b0, 1, 0);
    run_op("and",  OPC_OP, F3_AND,  F7_BASE, 32'hFF00FF00, 32'h0FF00FF0, 12'h0, 32'h0F000F00, 1'b0, 1, 0);

    // I-type ops (RS2 carries junk that must be ignored)
    run_op("addi_neg", OPC_OP_IMM, F3_ADD,  F7_BASE, 32'd10,       32'd99, 12'hFFF, 32'd9,        1'b0, 1, 0);
    run_op("addi_f7",  OPC_OP_IMM, F3_ADD,  F7_ALT,  32'd10,       32'd99, 12'h005, 32'd15,       1'b0, 1, 0);
    run_op("sltiu",    OPC_OP_IMM, F3_SLTU, F7_BASE, 32'd1,        32'd0,  12'hFFF, 32'd1,        1'b0, 1, 0);
    run_op("slti",     OPC_OP_IMM, F3_SLT,  F7_BASE, 32'd1,        32'd0,  12'hFFF, 32'd0,        1'b0, 1, 0);
    run_op("xori",     OPC_OP_IMM, F3_XOR,  F7_BASE, 32'h12345678, 32'd0,  12'h0FF, 32'h12345687, 1'b0, 1, 0);
    run_op("ori",      OPC_OP_IMM, F3_OR,   F7_BASE, 32'h0,        32'd0,  12'h800, 32'hFFFFF800, 1'b0, 1, 0);
    run_op("andi",     OPC_OP_IMM, F3_AND,  F7_BASE, 32'hFFFF1234, 32'd0,  12'h0F0, 32'h30,       1'b0, 1, 0);
    run_op("slli",     OPC_OP_IMM, F3_SLL,  F7_BASE, 32'd3,        32'd0,  12'h003, 32'h18,       1'b0, 1, 0);
    run_op("srli",     OPC_OP_IMM, F3_SR,   F7_BASE, 32'h80000000, 32'd0,  12'h01F, 32'd1,        1'b0, 1, 0);
    run_op("srai",     OPC_OP_IMM, F3_SR,   F7_BASE, 32'h80000000, 32'd0,  12'h41F, 32'hFFFFFFFF, 1'b0, 1, 3);

    // Illegal encodings
    run_op("ill_load",  7'b0000011, F3_ADD, F7_BASE, 32'd5, 32'd6, 12'h001, 32'd0, 1'b1, 1, 0);
    run_op("ill_f7xor", OPC_OP,     F3_XOR, F7_ALT,  32'd5, 32'd6, 12'h0,   32'd0, 1'b1, 1, 0);
    run_op("ill_f7odd", OPC_OP,     F3_ADD, 7'h05,   32'd5, 32'd6, 12'h0,   32'd0, 1'b1, 1, 0);

`ifdef ALU_MC_MDU_EN
    run_op("mul",    OPC_OP, F3_MUL,    F7_MULDIV, 32'd6,        32'd7,        12'h0, 32'd42,       1'b0, 1, 0);
    run_op("mulh",   OPC_OP, F3_MULH,   F7_MULDIV, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h0, 32'h0,        1'b0, 1, 0);
    run_op("mulh2",  OPC_OP, F3_MULH,   F7_MULDIV, 32'h80000000, 32'h80000000, 12'h0, 32'h40000000, 1'b0, 1, 0);
    run_op("mulhsu", OPC_OP, F3_MULHSU, F7_MULDIV, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h0, 32'hFFFFFFFF, 1'b0, 1, 0);
    run_op("mulhu",  OPC_OP, F3_MULHU,  F7_MULDIV, 32'hFFFFFFFF, 32'hFFFFFFFF, 12'h0, 32'hFFFFFFFE, 1'b0, 1, 0);
    run_op("div",    OPC_OP, F3_DIV,    F7_MULDIV, 32'hFFFFFFF9, 32'd2,        12'h0, 32'hFFFFFFFD, 1'b0, W+1, 0);
    run_op("rem",    OPC_OP, F3_REM,    F7_MULDIV, 32'hFFFFFFF9, 32'd2,        12'h0, 32'hFFFFFFFF, 1'b0, W+1, 0);
    run_op("divu0",  OPC_OP, F3_DIVU,   F7_MULDIV, 32'd100,      32'd0,        12'h0, 32'hFFFFFFFF, 1'b0, W+1, 0);
    run_op("remu0",  OPC_OP, F3_REMU,   F7_MULDIV, 32'd100,      32'd0,        12'h0, 32'd100,      1'b0, W+1, 0);
    run_op("div0",   OPC_OP, F3_DIV,    F7_MULDIV, 32'hFFFFFFFB, 32'd0,        12'h0, 32'hFFFFFFFF, 1'b0, W+1, 0);
    run_op("rem0",   OPC_OP, F3_REM,    F7_MULDIV, 32'hFFFFFFFB, 32'd0,        12'h0, 32'hFFFFFFFB, 1'b0, W+1, 0);
    run_op("divovf", OPC_OP, F3_DIV,    F7_MULDIV, 32'h80000000, 32'hFFFFFFFF, 12'h0, 32'h80000000, 1'b0, W+1, 0);
    run_op("removf", OPC_OP, F3_REM,    F7_MULDIV, 32'h80000000, 32'hFFFFFFFF, 12'h0, 32'h0,        1'b0, W+1, 2);
    run_op("divu",   OPC_OP, F3_DIVU,   F7_MULDIV, 32'hFFFFFFFF, 32'd3,        12'h0, 32'h55555555, 1'b0, W+1, 0);
    run_op("remu",   OPC_OP, F3_REMU,   F7_MULDIV, 32'd100,      32'd7,        12'h0, 32'd2,        1'b0, W+1, 0);

    // Reset 10 cycles into a divide: nothing may emerge afterwards.
    @(negedge clk);
    opcode = OPC_OP; Funct3 = F3_DIV; Funct7 = F7_MULDIV; RS1 = 32'd1000; RS2 = 32'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("rstdiv_valid", out_valid, 1'b0);
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < W + 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("rstdiv_no_result", seen, 1'b0);
    run_op("add_after_div_rst", OPC_OP, F3_ADD, F7_BASE, 32'd1, 32'd1, 12'h0, 32'd2, 1'b0, 1, 0);
`else
    run_op("ill_mul", OPC_OP, F3_MUL, F7_MULDIV, 32'd6,        32'd7, 12'h0, 32'd0, 1'b1, 1, 0);
    run_op("ill_div", OPC_OP, F3_DIV, F7_MULDIV, 32'hFFFFFFF9, 32'd2, 12'h0, 32'd0, 1'b1, 1, 0);
`endif

    // Reset while a result is waiting in DONE.
    @(negedge clk);
    opcode = OPC_OP; Funct3 = F3_ADD; Funct7 = F7_BASE; RS1 = 32'd2; RS2 = 32'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rstdone_pre", {out_valid, RD}, {1'b1, 32'd5});
    rst = 1'b1;
    #1;
    check("rstdone_valid", out_valid, 1'b0);
    check("rstdone_rd", RD, 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rstdone_idle", {in_ready, out_valid}, 2'b10);
    run_op("add_after_rst", OPC_OP, F3_ADD, F7_BASE, 32'd1, 32'd1, 12'h0, 32'd2, 1'b0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (power of two, 8..64).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  request present.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid && in_ready.
REQ-006 SHALL have ports RS1, RS2  input  WIDTH  operands.
REQ-007 SHALL have port Imm_reg  input  12  I-type immediate.
REQ-008 SHALL have ports opcode (7), Funct3 (3), Funct7 (7), all inputs, instruction fields.
REQ-009 SHALL have port out_valid  output  1  result present.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-011 SHALL have port RD  output  WIDTH  result.
REQ-012 SHALL have port illegal  output  1  qualifies RD; unsupported opcode/funct combination.

Function
REQ-013 SHALL decode opcode 0110011 (R-type) and 0010011 (I-type); all other opcodes complete with RD=0, illegal=1.
REQ-014 SHALL sign-extend Imm_reg to WIDTH for every I-type op.
REQ-015 SHALL take shift amount from low log2(WIDTH) bits of RS2 (R) or Imm_reg (I).
REQ-016 SHALL select SUB/SRA by Funct7=0x20 for R-type; SRAI by Imm_reg[10]; SUB never applies to I-type.
REQ-017 SHALL compare signed for SLT/SLTI and unsigned for SLTU/SLTIU, result 0 or 1.
REQ-018 SHALL hold FSM states IDLE, DIV, DONE; IDLE->DONE on accepted base op; IDLE->DIV on accepted divide; DIV->DONE after WIDTH iterations; DONE->IDLE on out_ready.
REQ-019 SHALL assert in_ready only in IDLE.
REQ-020 SHALL register results: base op out_valid asserted the cycle after acceptance (latency 1).
REQ-021 SHALL hold RD, illegal, out_valid stable while out_valid && !out_ready.
REQ-022 SHALL latch operands and fields at acceptance; input changes afterwards do not affect the result.
REQ-023 SHALL allow in_ready=0 in DONE, so back-to-back throughput is one op per 2 cycles minimum.

Reset
REQ-024 SHALL on rst force state IDLE, out_valid=0, RD=0, illegal=0, in_ready=1 after release, regardless of current state.
REQ-025 SHALL discard any in-flight divide on reset without emitting a result.

Configuration
REQ-026 SHALL compile the M-extension unit when macro ALU_MC_MDU_EN is defined: R-type Funct7=0x01 gives MUL/MULH/MULHSU/MULHU (latency 1) and DIV/DIVU/REM/REMU (latency WIDTH+1).
REQ-027 SHALL, without ALU_MC_MDU_EN, treat Funct7=0x01 R-type as illegal, RD=0, latency 1, DIV state unreachable.
REQ-028 SHALL return for divide-by-zero quotient all-ones, remainder=RS1; signed overflow (min/-1) quotient=RS1, remainder=0; both at normal latency.

Structure
REQ-029 SHALL place opcode constants, Funct3 op encodings, Funct7 constants and FSM state encoding in shared package alu_pkg.
REQ-030 SHALL implement the restoring radix-2 divider as sub-module alu_div (start, unsigned operands, done, quotient, remainder); sign handling stays in alu_mc.

Verification
REQ-031 SHALL cover: R-type Funct3=0 Funct7=0x20, RS1=5, RS2=7 -> RD=0xFFFFFFFE one cycle after acceptance.
REQ-032 SHALL cover: I-type SLTIU RS1=1, Imm_reg=0xFFF -> RD=1; SLTI same -> RD=0.
REQ-033 SHALL cover: SRAI RS1=0x80000000, Imm_reg=0x41F -> RD=0xFFFFFFFF; out_ready held low 3 cycles -> RD stable, in_ready=0.
REQ-034 SHALL cover (MDU_EN): DIV RS1=-7, RS2=2 -> RD=-3 after 33 cycles; REM -> RD=-1; DIVU RS2=0 -> RD=0xFFFFFFFF.
REQ-035 SHALL cover: rst asserted 10 cycles into DIV -> out_valid=0 immediately, no result emitted, next ADD 1+1 -> RD=2.
REQ-036 SHALL cover: opcode 0000011 -> illegal=1, RD=0; without MDU_EN Funct7=0x01 -> illegal=1.
